// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// iteration-counter sizing and the quotient reported for a zero divisor.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Counter must reach size, so it needs ceil(log2(size+1)) bits
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Sliced to the operand width by the user
    localparam logic [63:0] ZERO_QUOTIENT = '1;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference only when it does not borrow.
module seq_divider_div_step #(
    parameter int size = 8
) (
    input  logic [size:0]   partial_rem,
    input  logic            in_bit,
    input  logic [size-1:0] divisor,
    output logic [size:0]   next_rem,
    output logic            q_bit
);

    logic [size:0] shifted;
    logic [size:0] divisor_ext;

    always_comb begin
        shifted     = {partial_rem[size-1:0], in_bit};
        divisor_ext = {1'b0, divisor};
        q_bit       = (shifted >= divisor_ext);
        next_rem    = q_bit ? (shifted - divisor_ext) : shifted;
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider, one quotient bit per clock, with a start/done
// handshake; results are held stable for the seven-segment display driver.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int size = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [size-1:0] dividend,
    input  logic [size-1:0] divisor,
    output logic [size-1:0] consult,
    output logic [size-1:0] remainder,
    output logic            busy,
    output logic            done,
    output logic            div_zero
);

    localparam int            CW   = cnt_width(size);
    localparam logic [CW-1:0] LAST = CW'(size - 1);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [size-1:0] dq;
    logic [size-1:0] dvs;
    logic [size:0]   rem;
    logic [size:0]   next_rem;
    logic            q_bit;

    seq_divider_div_step #(.size(size)) u_step (
        .partial_rem (rem),
        .in_bit      (dq[size-1]),
        .divisor     (dvs),
        .next_rem    (next_rem),
        .q_bit       (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? FINISH : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // dq shifts dividend bits out of the MSB while quotient bits enter the LSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            dq        <= '0;
            dvs       <= '0;
            rem       <= '0;
            consult   <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dq  <= dividend;
                        dvs <= divisor;
                        rem <= '0;
                        cnt <= '0;
                        if (divisor == '0) begin
                            consult   <= ZERO_QUOTIENT[size-1:0];
                            remainder <= dividend;
                            div_zero  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    dq  <= {dq[size-2:0], q_bit};
                    rem <= next_rem;
                    cnt <= cnt + 1'b1;
                    // Outputs load only on the final step so the display never sees partials
                    if (cnt == LAST) begin
                        consult   <= {dq[size-2:0], q_bit};
                        remainder <= next_rem[size-1:0];
                        div_zero  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: table of operand/result vectors plus
// hand-written sequences for ignored start, reset abort and back-to-back runs.
module tb_seq_divider;

    localparam int SZ = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [SZ-1:0] dividend;
    logic [SZ-1:0] divisor;
    logic [SZ-1:0] consult;
    logic [SZ-1:0] remainder;
    logic          busy;
    logic          done;
    logic          div_zero;

    int checks   = 0;
    int failures = 0;

    seq_divider #(.size(SZ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .consult   (consult),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [SZ-1:0] dd;
        logic [SZ-1:0] dv;
        logic [SZ-1:0] q;
        logic [SZ-1:0] r;
        logic          z;
        int            lat;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Caller is positioned #1 after a posedge with the DUT idle
    task automatic run_div(input vec_t v);
        int n;
        dividend = v.dd;
        divisor  = v.dv;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check($sformatf("busy_after_start %0d/%0d", v.dd, v.dv), {31'd0, busy}, {31'd0, (v.dv != 0)});
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("latency %0d/%0d", v.dd, v.dv), n, v.lat);
        check($sformatf("consult %0d/%0d", v.dd, v.dv), {24'd0, consult}, {24'd0, v.q});
        check($sformatf("remainder %0d/%0d", v.dd, v.dv), {24'd0, remainder}, {24'd0, v.r});
        check($sformatf("div_zero %0d/%0d", v.dd, v.dv), {31'd0, div_zero}, {31'd0, v.z});
        check($sformatf("busy_in_finish %0d/%0d", v.dd, v.dv), {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check($sformatf("done_drop %0d/%0d", v.dd, v.dv), {31'd0, done}, 32'd0);
    endtask

    initial begin
        int ndone;
        int guard;
        vec_t v;

        vecs[0] = '{dd: 8'd100, dv: 8'd7,   q: 8'd14,  r: 8'd2,  z: 1'b0, lat: 8};
        vecs[1] = '{dd: 8'd255, dv: 8'd1,   q: 8'd255, r: 8'd0,  z: 1'b0, lat: 8};
        vecs[2] = '{dd: 8'd5,   dv: 8'd9,   q: 8'd0,   r: 8'd5,  z: 1'b0, lat: 8};
        vecs[3] = '{dd: 8'd0,   dv: 8'd3,   q: 8'd0,   r: 8'd0,  z: 1'b0, lat: 8};
        vecs[4] = '{dd: 8'd255, dv: 8'd255, q: 8'd1,   r: 8'd0,  z: 1'b0, lat: 8};
        vecs[5] = '{dd: 8'h5A,  dv: 8'd0,   q: 8'hFF,  r: 8'h5A, z: 1'b1, lat: 0};
        vecs[6] = '{dd: 8'd9,   dv: 8'd3,   q: 8'd3,   r: 8'd0,  z: 1'b0, lat: 8};

        rst_n    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #2 rst_n = 1'b0;
        #1;
        check("reset consult", {24'd0, consult}, 32'd0);
        check("reset remainder", {24'd0, remainder}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset div_zero", {31'd0, div_zero}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_div(vecs[i]);
        end

        // Second start during CALC must be dropped; outputs hold 9/3 result meanwhile
        dividend = 8'd20;
        divisor  = 8'd6;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        dividend = 8'd200;
        divisor  = 8'd10;
        start    = 1'b1;
        check("hold consult mid-op", {24'd0, consult}, 32'd3);
        check("hold remainder mid-op", {24'd0, remainder}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("ignored start done count", ndone, 1);
        check("ignored start consult", {24'd0, consult}, 32'd3);
        check("ignored start remainder", {24'd0, remainder}, 32'd2);

        // Reset abort at E0+4 of 100/7
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort consult", {24'd0, consult}, 32'd0);
        check("abort remainder", {24'd0, remainder}, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
            if (k == 2) rst_n = 1'b1;
        end
        check("abort no done", ndone, 0);
        check("abort div_zero", {31'd0, div_zero}, 32'd0);
        v = '{dd: 8'd100, dv: 8'd7, q: 8'd14, r: 8'd2, z: 1'b0, lat: 8};
        run_div(v);

        // Back-to-back: start held high, done expected at E0+8, +18, +28
        dividend = 8'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        ndone    = 0;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                check($sformatf("b2b done position e=%0d", e), e % 10, 8);
                check("b2b consult", {24'd0, consult}, 32'd10);
                check("b2b remainder", {24'd0, remainder}, 32'd0);
            end
        end
        start = 1'b0;
        check("b2b done count", ndone, 3);
        guard = 0;
        while ((busy || done) && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("b2b drain", {31'd0, (busy || done)}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring (shift-subtract) unsigned divider, one quotient bit per clock.
- Sits directly upstream of the seven-segment display driver. Its registered consult/remainder outputs feed that driver's consult/remainder inputs unchanged, with the same width parameter.
- A start/done handshake lets switch or button logic launch a division and know when the displayed result is valid.

Parameters:
- size, 8, operand/result width in bits (must match the display driver's size)

Ports:
- clk  input  1  system clock (100 MHz board clock)
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  size  unsigned dividend, sampled at accepted start
- divisor  input  size  unsigned divisor, sampled at accepted start
- consult  output  size  registered quotient, held until next completion
- remainder  output  size  registered remainder, held until next completion
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle completion pulse
- div_zero  output  1  sticky flag: last completed division had divisor==0

Behaviour:
- Clock and reset: one clock `clk`. Reset is asynchronous and active-low on `rst_n`.
- Reset values: consult=0, remainder=0, busy=0, done=0, div_zero=0; state=IDLE; iteration counter=0; internal regs=0.
- FSM states: IDLE, CALC, FINISH.
- IDLE, start=1 at edge E0:
  - Latch dividend into the shift register; latch divisor.
  - Clear the partial remainder (size+1 bits) and the counter.
  - Go to CALC; busy=1 from E0.
- IDLE, start=1 with divisor==0: go to FINISH at E0 with no iterations (zero path).
- CALC iteration (every edge):
  - Form {partial_rem[size-1:0], dq_msb}, i.e. shift left by one bit.
  - Trial-subtract the divisor, zero-extended to size+1 bits.
  - If the result is non-negative, keep it and shift in quotient bit 1; else keep the shifted value and shift in 0.
  - Counter increments each iteration.
- CALC exit: after exactly size iterations (edges E0+1 .. E0+size), the transition at E0+size goes to FINISH.
- FINISH (one cycle):
  - At the FINISH entry edge, consult and remainder are loaded from the internal registers.
  - done=1 and busy=0 during the FINISH cycle.
  - The next edge returns to IDLE; done=0.
- Latency: start accepted at E0; done high for the cycle after edge E0+size. Results are valid from that same cycle, so total latency is size+1 edges to IDLE.
- Zero divisor:
  - FINISH is entered at E0.
  - consult = all ones; remainder = latched dividend; div_zero=1.
  - done pulses in the cycle after E0.
- div_zero: updated on every completion (set on the zero path, cleared on a normal divide).
- start while busy or in FINISH: ignored, not queued. Operand changes during CALC have no effect.
- start held high continuously: a new division begins in the IDLE cycle after FINISH, i.e. back-to-back every size+2 edges.
- consult/remainder change only at FINISH entry; they are never transient mid-operation (the display is driven directly).
- Reset mid-operation: immediate abort; all outputs return to reset values; no done pulse.
- Arithmetic: all unsigned. The partial remainder is size+1 bits wide to hold the subtraction borrow, and remainder < divisor always holds for a nonzero divisor.

Decomposition:
- Shared package holds:
  - State encoding constants for IDLE/CALC/FINISH (2 bits).
  - The counter width, ceil(log2(size+1)).
  - The zero-divisor quotient constant (all ones).
- One natural sub-module: div_step. It is combinational: given partial_rem, the incoming bit and divisor, it returns next partial_rem and the quotient bit. It is instantiated once in the CALC datapath and can be unit-tested exhaustively for size=4.

Test Plan:
- Normal divide: reset, then dividend=100, divisor=7, start for one cycle -> busy for 8 cycles; done pulses in the 9th cycle after E0; consult=14, remainder=2, div_zero=0.
- Edge operands:
  - 255/1 -> consult=255, remainder=0.
  - 5/9 -> consult=0, remainder=5.
  - 0/3 -> consult=0, remainder=0.
  - 255/255 -> consult=1, remainder=0.
- Divide by zero: dividend=0x5A, divisor=0, start -> done in the cycle after E0; consult=0xFF, remainder=0x5A, div_zero=1. A following 9/3 -> consult=3, remainder=0, div_zero=0.
- Ignored start: start 20/6, then reassert start with 200/10 during CALC -> exactly one done; consult=3, remainder=2. Outputs hold the previous result until FINISH.
- Reset abort: drop rst_n at E0+4 of 100/7 -> outputs go to 0 asynchronously; no done pulse. After release, a new 100/7 completes normally.
- Back-to-back: start held high with 50/5 -> done every 10 edges; consult=10, remainder=0 each time.
